// File: rtl/bf_uart_tx_pkg.sv
// ---------------------------------------------------------------------------
// bf_uart_tx_pkg
// Shared definitions for the character UART transmitter slice.
//   DEFAULT_DATA_WIDTH : character width used when the top is not overridden
//                        (mirrors the shared DATA_WIDTH define of the core)
//   FRAME_EXTRA_BITS   : start + stop bits framing each character (8N1)
//   tx_state_t         : transmitter FSM states
// ---------------------------------------------------------------------------
package bf_uart_tx_pkg;

   localparam int DEFAULT_DATA_WIDTH = 8;
   localparam int FRAME_EXTRA_BITS   = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_t;

endpackage

// File: rtl/bf_uart_tx_byte_fifo.sv
// ---------------------------------------------------------------------------
// byte_fifo
// Small synchronous FIFO with show-ahead read data.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_data this cycle (ignored when full unless popping)
//   push_data   : WIDTH-bit write data
//   pop         : remove the head entry this cycle (ignored when empty)
//   pop_data    : current head entry (valid while empty is low)
//   full, empty : occupancy flags
//   count       : number of stored entries, 0..DEPTH
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module byte_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [WIDTH-1:0] push_data,
   input  logic          pop,
   output logic [WIDTH-1:0] pop_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // A push into a full FIFO still succeeds when a pop frees a slot in the
   // same cycle; otherwise the write is simply not performed.
   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr];

   // Storage array carries no reset; only occupied entries are ever read.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap modulo DEPTH by overflowing their AW-bit width.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (do_pop && !do_push) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/bf_uart_tx.sv
// ---------------------------------------------------------------------------
// bf_uart_tx
// Buffered 8N1 serial transmitter fed by the core's character output port.
//   clk, rst_n  : clock, asynchronous active-low reset
//   output_en   : character strobe; data follows one cycle after the strobe
//   output_data : DATA_WIDTH-bit character, captured on the strobe's fall
//   tx          : serial line, idle high, LSB first
//   busy        : FIFO non-empty or a frame in progress
//   overflow    : sticky, set when a character was dropped on a full FIFO
//   fifo_count  : characters waiting in the FIFO
// Each character takes one IDLE pop cycle plus (DATA_WIDTH+2)*CLKS_PER_BIT
// cycles on the line.
// ---------------------------------------------------------------------------
module bf_uart_tx
   import bf_uart_tx_pkg::*;
#(
   parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 8,
   localparam int CW          = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  output_en,
   input  logic [DATA_WIDTH-1:0] output_data,
   output logic                  tx,
   output logic                  busy,
   output logic                  overflow,
   output logic [CW-1:0]         fifo_count
);

   localparam int BW = $clog2(DATA_WIDTH + 1);
   localparam logic [15:0]  BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_WIDTH - 1);

   tx_state_t               state;
   logic                    en_d;
   logic                    capture;
   logic [15:0]             baud_cnt;
   logic [BW-1:0]           bit_cnt;
   logic [DATA_WIDTH-1:0]   shift;
   logic [DATA_WIDTH-1:0]   fifo_head;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic                    fifo_pop;

   // The core's data becomes valid the cycle after its strobe, so the
   // character is taken on the falling edge of the registered strobe.
   // A long strobe therefore still produces a single capture.
   assign capture  = en_d && !output_en;
   assign fifo_pop = (state == ST_IDLE) && !fifo_empty;
   assign busy     = (fifo_count != '0) || (state != ST_IDLE);

   byte_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (capture),
      .push_data (output_data),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Strobe edge detection and the sticky overflow flag. A capture into a
   // full FIFO is only a drop when the transmitter is not popping that cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_d     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         en_d <= output_en;
         if (capture && fifo_full && !fifo_pop) begin
            overflow <= 1'b1;
         end
      end
   end

   // Transmit FSM. tx is registered and always set one cycle ahead of the
   // state it belongs to, so the line changes on the same edge as the state.
   // The baud down-counter is reloaded on every state or bit change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         tx       <= 1'b1;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  shift    <= fifo_head;
                  bit_cnt  <= '0;
                  baud_cnt <= BAUD_RELOAD;
                  tx       <= 1'b0;
                  state    <= ST_START;
               end
            end
            ST_START: begin
               if (baud_cnt == '0) begin
                  baud_cnt <= BAUD_RELOAD;
                  tx       <= shift[0];
                  state    <= ST_DATA;
               end else begin
                  baud_cnt <= baud_cnt - 1'b1;
               end
            end
            ST_DATA: begin
               if (baud_cnt == '0) begin
                  baud_cnt <= BAUD_RELOAD;
                  if (bit_cnt == LAST_BIT) begin
                     tx    <= 1'b1;
                     state <= ST_STOP;
                  end else begin
                     shift   <= shift >> 1;
                     bit_cnt <= bit_cnt + 1'b1;
                     tx      <= shift[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt - 1'b1;
               end
            end
            ST_STOP: begin
               if (baud_cnt == '0) begin
                  state <= ST_IDLE;
               end else begin
                  baud_cnt <= baud_cnt - 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bf_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_bf_uart_tx
// Self-checking bench for bf_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=8.
// A queue-based model tracks buffered characters and the position inside
// the current frame; the expected line level is looked up from the frame's
// bit list. Directed scenarios pin the model with literal expectations and
// a randomized phase exercises gaps, strobe lengths and overflow.
// ---------------------------------------------------------------------------
module tb_bf_uart_tx;

   localparam int DW    = 8;
   localparam int CPB   = 4;
   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;
   localparam int FRAME = (DW + 2) * CPB;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          output_en;
   logic [DW-1:0] output_data;
   logic          tx;
   logic          busy;
   logic          overflow;
   logic [CW-1:0] fifo_count;

   int checks   = 0;
   int failures = 0;

   // Model state
   bit            m_en_d;
   logic [DW-1:0] m_q [$];
   logic [DW-1:0] m_log [$];
   bit            m_active;
   int            m_pos;
   logic [DW-1:0] m_cur;
   bit            m_ovf;
   int            m_pushes;
   bit            cmp_en = 1'b0;
   int            peak_count;

   always #5 clk = ~clk;

   bf_uart_tx #(
      .DATA_WIDTH   (DW),
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .output_en   (output_en),
      .output_data (output_data),
      .tx          (tx),
      .busy        (busy),
      .overflow    (overflow),
      .fifo_count  (fifo_count)
   );

   task automatic check_val(input string name, input logic [31:0] actual,
                            input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Frame bit list: index 0 start, 1..DW data LSB first, DW+1 stop.
   function automatic logic frame_bit(input logic [DW-1:0] ch, input int idx);
      if (idx == 0) return 1'b0;
      if (idx == DW + 1) return 1'b1;
      return ch[idx-1];
   endfunction

   // Behavioural model: a frame lasts FRAME cycles after the pop cycle; a
   // new frame starts only from a non-transmitting cycle with data queued.
   bit cap;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_en_d   = 1'b0;
         m_q.delete();
         m_active = 1'b0;
         m_pos    = 0;
         m_ovf    = 1'b0;
      end else begin
         cap    = m_en_d && !output_en;
         m_en_d = output_en;
         if (m_active) begin
            if (m_pos == FRAME - 1) m_active = 1'b0;
            else m_pos++;
         end else if (m_q.size() != 0) begin
            m_cur    = m_q.pop_front();
            m_log.push_back(m_cur);
            m_active = 1'b1;
            m_pos    = 0;
         end
         if (cap) begin
            if (m_q.size() < DEPTH) begin
               m_q.push_back(output_data);
               m_pushes++;
            end else begin
               m_ovf = 1'b1;
            end
         end
      end
   end

   // Per-cycle comparison against the model on the inactive clock edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         check_val("tx", tx, m_active ? frame_bit(m_cur, m_pos / CPB) : 1'b1);
         check_val("busy", busy, (m_active || m_q.size() != 0) ? 1 : 0);
         check_val("fifo_count", fifo_count, m_q.size());
         check_val("overflow", overflow, m_ovf);
         if (int'(fifo_count) > peak_count) peak_count = int'(fifo_count);
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Strobe high for 'hold' cycles, then present data; returns #1 after the
   // capture edge.
   task automatic applyStimulus(input logic [DW-1:0] d, input int hold);
      output_en = 1'b1;
      tick(hold);
      output_en   = 1'b0;
      output_data = d;
      tick(1);
      output_data = $urandom;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy && n < 5000) begin
         tick(1);
         n++;
      end
      if (busy) check_val(name, busy, 0);
      tick(2);
   endtask

   task automatic count_tx_falls(input int cycles, output int falls);
      logic prev;
      falls = 0;
      prev  = tx;
      repeat (cycles) begin
         tick(1);
         if (prev && !tx) falls++;
         prev = tx;
      end
   endtask

   initial begin
      logic exp_bits [10];
      int   falls;
      int   log0;
      int   p0;

      exp_bits = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      rst_n       = 1'b0;
      output_en   = 1'b0;
      output_data = '0;
      peak_count  = 0;
      m_pushes    = 0;
      tick(2);
      cmp_en = 1'b1;
      tick(1);
      rst_n = 1'b1;
      tick(1);

      // Idle after reset
      check_val("reset_tx", tx, 1);
      check_val("reset_busy", busy, 0);
      check_val("reset_count", fifo_count, 0);
      count_tx_falls(100, falls);
      check_val("idle_no_edge", falls, 0);

      // Single character 0x48: latency and bit pattern
      applyStimulus(8'h48, 1);
      check_val("latency_c1", tx, 1);
      tick(1);
      check_val("latency_c2", tx, 0);
      for (int b = 0; b < 10; b++) begin
         check_val($sformatf("bit%0d", b), tx, exp_bits[b]);
         tick(CPB);
      end
      check_val("busy_after_stop", busy, 0);
      tick(3);

      // Long strobe yields a single frame
      p0   = m_pushes;
      log0 = m_log.size();
      applyStimulus(8'h41, 5);
      wait_idle("timeout_long_strobe");
      check_val("long_strobe_pushes", m_pushes - p0, 1);
      check_val("long_strobe_frames", m_log.size() - log0, 1);
      check_val("long_strobe_char", m_log[m_log.size()-1], 8'h41);

      // Nine back-to-back characters
      log0       = m_log.size();
      peak_count = 0;
      for (int i = 0; i < 9; i++) applyStimulus(8'h30 + 8'(i), 1);
      wait_idle("timeout_burst9");
      check_val("burst9_peak", peak_count, 8);
      check_val("burst9_overflow", overflow, 0);
      check_val("burst9_frames", m_log.size() - log0, 9);
      for (int i = 0; i < 9; i++)
         check_val($sformatf("burst9_order%0d", i), m_log[log0+i], 8'h30 + 8'(i));

      // Ten back-to-back characters: last one dropped
      log0 = m_log.size();
      for (int i = 0; i < 10; i++) applyStimulus(8'h50 + 8'(i), 1);
      check_val("burst10_overflow", overflow, 1);
      wait_idle("timeout_burst10");
      check_val("burst10_frames", m_log.size() - log0, 9);
      check_val("burst10_last", m_log[m_log.size()-1], 8'h58);
      check_val("overflow_sticky", overflow, 1);

      // Randomized traffic
      for (int n = 0; n < 40; n++) begin
         applyStimulus(8'($urandom), $urandom_range(1, 3));
         tick($urandom_range(0, 60));
      end
      wait_idle("timeout_random");

      // Reset in the middle of a data bit with three queued
      applyStimulus(8'hA5, 1);
      applyStimulus(8'h11, 1);
      applyStimulus(8'h22, 1);
      applyStimulus(8'h33, 1);
      check_val("pre_reset_count", fifo_count, 3);
      tick(8);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("mid_reset_tx", tx, 1);
      check_val("mid_reset_count", fifo_count, 0);
      check_val("mid_reset_busy", busy, 0);
      check_val("mid_reset_overflow", overflow, 0);
      tick(2);
      rst_n = 1'b1;
      log0  = m_log.size();
      count_tx_falls(200, falls);
      check_val("post_reset_falls", falls, 0);
      check_val("post_reset_frames", m_log.size() - log0, 0);

      // Short random run after reset
      for (int n = 0; n < 15; n++) begin
         applyStimulus(8'($urandom), $urandom_range(1, 4));
         tick($urandom_range(0, 30));
      end
      wait_idle("timeout_random2");

      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bf_uart_tx.md
BF_UART_TX -- requirements
Module: bf_uart_tx

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default `DATA_WIDTH (8), the character width.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 16, the clk cycles per serial bit; legal range is 2..65535.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 8, the buffered characters; must be a power of 2.
REQ-004 Reset is rst_n, asynchronous, active-low; clock is clk.
REQ-005 Port: clk  input  1  system clock.
REQ-006 Port: rst_n  input  1  asynchronous active-low reset.
REQ-007 Port: output_en  input  1  character strobe from the core output port.
REQ-008 Port: output_data  input  DATA_WIDTH  character from the core output port.
REQ-009 Port: tx  output  1  serial line, 8N1, idle high.
REQ-010 Port: busy  output  1  high while the FIFO is non-empty or the shifter is active.
REQ-011 Port: overflow  output  1  sticky flag; a character was dropped.
REQ-012 Port: fifo_count  output  clog2(FIFO_DEPTH)+1  number of characters buffered.

Function
REQ-013 Capture rule: the block SHALL register output_en as en_d and capture output_data on the first clk where en_d=1 and output_en=0, because the core's data is valid one cycle after its strobe.
REQ-014 One capture SHALL push exactly one entry; a strobe held high for N cycles still yields one push.
REQ-015 Push when full: the character SHALL be dropped, overflow SHALL be set to 1, and the FIFO contents SHALL remain unchanged.
REQ-016 Simultaneous push and pop: both SHALL take effect in the same cycle, leaving fifo_count unchanged.
REQ-017 Simultaneous push and pop when full: both SHALL take effect and overflow SHALL not be set.
REQ-018 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-019 TX FSM states SHALL be IDLE, START, DATA, STOP.
REQ-020 IDLE: tx=1; when the FIFO is non-empty, the block SHALL pop the head into the shift register, clear the bit counter, and go to START on the next clk.
REQ-021 START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-022 DATA: tx=shift[0], LSB first; each bit is held CLKS_PER_BIT cycles, then the register shifts right and the bit counter increments; after DATA_WIDTH bits, go to STOP.
REQ-023 STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE; back-to-back characters therefore have no extra idle cycle beyond the IDLE pop cycle.
REQ-024 Character latency: tx SHALL fall 2 clk cycles after the capture cycle when the FIFO was empty and the FSM was IDLE.
REQ-025 Frame length SHALL be (DATA_WIDTH+2)*CLKS_PER_BIT cycles, plus 1 IDLE cycle per character.
REQ-026 The baud counter SHALL be a down-counter reloaded on every state or bit change.
REQ-027 tx SHALL be driven from a flop, never combinationally.
REQ-028 busy SHALL equal (fifo_count!=0) OR (state!=IDLE).
REQ-029 overflow SHALL clear only on reset.

Reset
REQ-030 On rst_n low, asynchronously: tx=1, busy=0, overflow=0, fifo_count=0, state=IDLE, pointers=0, en_d=0, baud counter=0, shift register=0.
REQ-031 Reset mid-frame SHALL abort the frame; tx SHALL return high immediately and buffered characters SHALL be discarded.
REQ-032 The first capture after reset release SHALL require a new 1->0 transition of output_en after en_d has sampled 1.

Structure
REQ-033 DATA_WIDTH SHALL come from the shared define.v; no new shared constants are required.
REQ-034 The FSM state encodings SHALL be local parameters.
REQ-035 One sub-module SHALL be used: byte_fifo, a synchronous FIFO with push, pop, full, empty and count, parameterised by width and depth.
REQ-036 The FSM, capture logic and shifter SHALL live in bf_uart_tx.

Verification
REQ-037 Idle reset, CLKS_PER_BIT=4: tx=1, busy=0, fifo_count=0, no tx edge for 100 cycles.
REQ-038 Strobe output_en one cycle, then data 8'h48 on the next cycle: tx falls at capture+2; line reads 0,0,0,0,1,0,0,1,0,1 with each bit 4 cycles; busy drops after the stop bit.
REQ-039 Strobe held high 5 cycles with data 8'h41: exactly one frame is sent.
REQ-040 Push 9 characters 8'h30..8'h38 back-to-back while the first is transmitting: 8'h30..8'h38 are all sent in order, overflow stays 0, and fifo_count peaks at 8.
REQ-041 Push 10 characters while the first is in START: the 10th is dropped, overflow=1 sticky, and nine frames are sent.
REQ-042 Assert rst_n low mid-DATA of 8'hA5 with 3 queued: tx goes high that cycle, fifo_count=0, and no further frames are sent after release.
